mmio_uart_tx: RTL

//  Memory-mapped responder on the backend data bus, the target end of the load/store path.

---
 rtl/mmio_uart_tx_pkg.sv | 27 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 60 ++++++
 rtl/mmio_uart_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions, FSM encoding and the baud reload helper.
package mmio_uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // DIV of 0 and 1 both mean one clock per bit.
  function automatic logic [15:0] baud_reload(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO holding queued TX bytes; head is the oldest entry.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the backend SRAM-style data bus.
// Decodes its own 16-byte window; stores queue bytes, loads return STATUS and DIV.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [12:0] BASE    = 13'h1FFF,
  parameter int          DEPTH   = 16,
  parameter logic [15:0] DIV_RST = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        oe,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [14:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        dout_en,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel, rd, wr, push, pop, ovf_clr;
  logic [1:0]    off;
  logic          full, empty, busy, bit_end, start_frame;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic [31:0]   status;
  logic          unused_bits;

  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;
  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;

  assign unused_bits = ^{din[31:16], be[3:2]};

  // Reads are suppressed while reset is held so the load bus stays released.
  always_comb begin
    sel     = ~ce & (addr[14:2] == BASE);
    off     = addr[1:0];
    rd      = rst & sel & ~oe & we;
    wr      = sel & ~we;
    push    = wr & (off == OFF_TXDATA) & ~be[0];
    ovf_clr = wr & (off == OFF_STATUS) & ~be[0] & din[ST_OVF_BIT];
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (din[7:0]),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign busy    = (state_q != TX_IDLE);
  assign bit_end = (cnt_q == 16'd0);
  assign irq     = ~(empty & ~busy);
  assign tx      = tx_q;
  assign dout_en = ~rd;

  always_comb begin
    status                      = '0;
    status[ST_FULL_BIT]         = full;
    status[ST_EMPTY_BIT]        = empty;
    status[ST_BUSY_BIT]         = busy;
    status[ST_OVF_BIT]          = ovf_q;
    status[ST_CNT_LSB +: 8]     = 8'(count);
    dout = '0;
    if (rd) begin
      case (off)
        OFF_STATUS: dout = status;
        OFF_DIV:    dout = {16'h0000, div_q};
        default:    dout = '0;
      endcase
    end
  end

  // Overflow set takes priority over a clear in the same cycle.
  always_comb begin
    div_d = div_q;
    if (wr && (off == OFF_DIV)) begin
      if (!be[0]) div_d[7:0]  = din[7:0];
      if (!be[1]) div_d[15:8] = din[15:8];
    end
    ovf_d = ovf_q;
    if (ovf_clr)      ovf_d = 1'b0;
    if (push && full) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!empty) state_d = TX_START;
      TX_START: if (bit_end) state_d = TX_DATA;
      TX_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = TX_STOP;
      TX_STOP:  if (bit_end) state_d = empty ? TX_IDLE : TX_START;
      default:  state_d = TX_IDLE;
    endcase
  end

  // A new frame begins from IDLE or straight out of a finished stop bit.
  always_comb begin
    start_frame = ~empty & ((state_q == TX_IDLE) | ((state_q == TX_STOP) & bit_end));
    pop         = 1'b0;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    if (busy && !bit_end) cnt_d = cnt_q - 16'd1;
    case (state_q)
      TX_IDLE: tx_d = 1'b1;
      TX_START: begin
        if (bit_end) begin
          tx_d  = shreg_q[0];
          bit_d = 3'd0;
          cnt_d = baud_reload(div_q);
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = baud_reload(div_q);
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shreg_q[1];
            shreg_d = {1'b0, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          tx_d  = 1'b1;
          cnt_d = baud_reload(div_q);
        end
      end
      default: tx_d = 1'b1;
    endcase
    if (start_frame) begin
      pop     = 1'b1;
      shreg_d = head;
      tx_d    = 1'b0;
      cnt_d   = baud_reload(div_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= TX_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= DIV_RST;
      ovf_q <= 1'b0;
      cnt_q <= 16'd0;
      bit_q <= 3'd0;
      tx_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      tx_q  <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule
